regfile_operand_fetch: RTL

- Client-side master of the register file port: drives the read/write request interface (read-select pair, write select, write value, single `op` bit) and consumes the two read-data words.
- Sits between decode and execute. Accepts decoded source/destination indices and issues register-file reads. Merges writeback traffic onto the same port, with writes taking priority.
- Tracks pending destinations in a scoreboard for RAW stalls and forwards same-cycle writeback data into captured operands.

---
 rtl/regfile_operand_fetch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage: checks a pending-write scoreboard for RAW hazards, reads the
// register file, forwards same-cycle writeback data and hands operands to execute.
module regfile_operand_fetch #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_wen,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   rf_reg_num_1,
  output logic [AW-1:0]   rf_reg_num_2,
  output logic [AW-1:0]   rf_reg_num,
  output logic [XLEN-1:0] rf_val,
  output logic            rf_op,
  input  logic [XLEN-1:0] rf_reg_1,
  input  logic [XLEN-1:0] rf_reg_2,
  output logic [NREG-1:0] busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  state_t          state_q;
  logic [AW-1:0]   rs1_q, rs2_q, rd_q;
  logic            rd_wen_q;
  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q;
  logic [XLEN-1:0] out_rs1_val_q, out_rs2_val_q;
  logic [AW-1:0]   out_rd_q;
  logic            out_rd_wen_q;

  logic            wb_wr;
  logic [NREG-1:0] wb_clr_mask, busy_clr, set_mask;
  logic            hazard, handshake;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Writes to x0 are dropped entirely: no rf write and no scoreboard change.
  assign wb_wr       = wb_valid && (wb_rd != '0);
  assign wb_clr_mask = wb_wr ? (ONE_HOT0 << wb_rd) : '0;
  assign busy_clr    = busy_q & ~wb_clr_mask;

  // Hazard looks at the scoreboard after this cycle's writeback clear.
  assign hazard = ((rs1_q != '0) && busy_clr[rs1_q]) ||
                  ((rs2_q != '0) && busy_clr[rs2_q]);

  assign handshake = (state_q == S_HOLD) && out_ready;
  assign set_mask  = (handshake && out_rd_wen_q && (out_rd_q != '0)) ?
                     (ONE_HOT0 << out_rd_q) : '0;
  // OR-ing the set after the clear lets a dispatch beat a same-index writeback.
  assign busy_d    = (busy_clr | set_mask) & ~ONE_HOT0;

  assign fwd_rs1 = (rs1_q == '0) ? '0 :
                   (wb_valid && (wb_rd == rs1_q)) ? wb_data : rf_reg_1;
  assign fwd_rs2 = (rs2_q == '0) ? '0 :
                   (wb_valid && (wb_rd == rs2_q)) ? wb_data : rf_reg_2;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    rf_op        = 1'b0;
    rf_reg_num   = '0;
    rf_val       = '0;
    rf_reg_num_1 = '0;
    rf_reg_num_2 = '0;
    if (!rst) begin
      if (wb_wr) begin
        rf_op      = 1'b1;
        rf_reg_num = wb_rd;
        rf_val     = wb_data;
      end else if ((state_q == S_ISSUE) && !wb_valid) begin
        rf_reg_num_1 = rs1_q;
        rf_reg_num_2 = rs2_q;
      end
    end
  end

  // NOTE: state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      rd_wen_q      <= 1'b0;
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
      out_rd_q      <= '0;
      out_rd_wen_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            rd_q     <= in_rd;
            rd_wen_q <= in_rd_wen;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!hazard) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!wb_valid) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          out_rs1_val_q <= fwd_rs1;
          out_rs2_val_q <= fwd_rs2;
          out_rd_q      <= rd_q;
          out_rd_wen_q  <= rd_wen_q;
          out_valid_q   <= 1'b1;
          state_q       <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_rs1_val = out_rs1_val_q;
  assign out_rs2_val = out_rs2_val_q;
  assign out_rd      = out_rd_q;
  assign out_rd_wen  = out_rd_wen_q;
  assign busy        = busy_q;

endmodule
